// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encodings, default sizing
// and the word returned whenever no valid instruction is being served.
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam int unsigned DEPTH_DEFAULT  = 12;
    localparam int unsigned INSN_W_DEFAULT = 32;
    localparam logic [INSN_W_DEFAULT-1:0] NOP_INSN_DEFAULT = 32'h0000_0000;

    // Address width needed to index a store of the given depth (at least 1 bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : program_loader_pkg

// File: rtl/program_loader_insn_store.sv
// Instruction storage: DEPTH x INSN_W register array, one synchronous write
// port and one combinational read port. Contents are deliberately not reset.
module program_loader_insn_store
    import program_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned INSN_W = INSN_W_DEFAULT,
    parameter int unsigned AW     = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [INSN_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [INSN_W-1:0] rd_data
);

    logic [INSN_W-1:0] mem [DEPTH];

    // Write the addressed slot; addresses beyond DEPTH-1 are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Zero-latency read mux; unpopulated addresses read as zero rather than X.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule : program_loader_insn_store

// File: rtl/program_loader.sv
// Instruction-side partner of the processor: takes a program over a
// valid/ready load stream, then serves instructions for PC while running.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accepting program words (load_ready while space remains)
//   LOADED | program stored, waiting for start
//   RUN    | serving mem[PC] to the processor, counting cycles
//   HALT   | processor reported done; counters frozen, restartable
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned        DEPTH    = DEPTH_DEFAULT,
    parameter int unsigned        INSN_W   = INSN_W_DEFAULT,
    parameter logic [INSN_W-1:0]  NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [0:INSN_W-1] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              clear,
    input  logic [7:0]        PC,
    input  logic              done,
    output logic [0:INSN_W-1] instruction,
    output logic [1:0]        state,
    output logic [7:0]        prog_len,
    output logic              overflow,
    output logic              pc_fault,
    output logic [15:0]       cycle_count
);

    localparam int unsigned AW      = addr_width(DEPTH);
    localparam logic [7:0]  DEPTH_8 = 8'(DEPTH);

    state_t state_q;
    state_t state_d;

    logic              accept;
    logic              last_slot;
    logic              pc_in_range;
    logic              run_entry;
    logic [INSN_W-1:0] rd_data;

    assign load_ready  = (state_q == ST_IDLE) && (prog_len < DEPTH_8);
    assign accept      = load_valid && load_ready;
    assign last_slot   = (prog_len == (DEPTH_8 - 8'd1));
    assign pc_in_range = (PC < prog_len);
    assign run_entry   = (state_d == ST_RUN) && (state_q != ST_RUN);
    assign state       = state_q;

    program_loader_insn_store #(
        .DEPTH  (DEPTH),
        .INSN_W (INSN_W),
        .AW     (AW)
    ) u_store (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (prog_len[AW-1:0]),
        .wr_data (load_data),
        .rd_addr (PC[AW-1:0]),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats everything, done beats start in RUN.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Last word, or the store just filled up without one.
                    if (accept && (load_last || last_slot)) begin
                        state_d = ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (done) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Program length and overflow flag, both reset by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_len <= 8'd0;
            overflow <= 1'b0;
        end else if (clear) begin
            prog_len <= 8'd0;
            overflow <= 1'b0;
        end else if (accept) begin
            prog_len <= prog_len + 8'd1;
            // Store filled with no last marker: program did not fit.
            if (last_slot && !load_last) begin
                overflow <= 1'b1;
            end
        end
    end

    // Run statistics: cleared on entry to RUN, frozen outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= 16'd0;
            pc_fault    <= 1'b0;
        end else if (clear || run_entry) begin
            cycle_count <= 16'd0;
            pc_fault    <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (!pc_in_range) begin
                pc_fault <= 1'b1;
            end
            // The halting cycle is not counted.
            if (!done && (cycle_count != 16'hFFFF)) begin
                cycle_count <= cycle_count + 16'd1;
            end
        end
    end

    // Serve the stored word only for in-range fetches while running.
    always_comb begin
        instruction = NOP_INSN;
        if ((state_q == ST_RUN) && pc_in_range) begin
            instruction = rd_data;
        end
    end

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader.
module tb_program_loader;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [0:31] load_data;
    logic        load_last;
    logic        start;
    logic        clear;
    logic [7:0]  PC;
    logic        done;
    logic [0:31] instruction;
    logic [1:0]  state;
    logic [7:0]  prog_len;
    logic        overflow;
    logic        pc_fault;
    logic [15:0] cycle_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] prog3 [3];

    program_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .start       (start),
        .clear       (clear),
        .PC          (PC),
        .done        (done),
        .instruction (instruction),
        .state       (state),
        .prog_len    (prog_len),
        .overflow    (overflow),
        .pc_fault    (pc_fault),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        prog3[0] = 32'h2001_0005;
        prog3[1] = 32'h2002_0003;
        prog3[2] = 32'h0022_1820;

        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; clear = 1'b0; PC = 8'd0; done = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pc_fault", 32'(pc_fault), 32'd0);
        check("rst_cycle_count", 32'(cycle_count), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        #10 rst_n = 1'b1;
        tick();

        // Three-word program.
        for (int i = 0; i < 3; i++) load_word(prog3[i], i == 2);
        check("p3_prog_len", 32'(prog_len), 32'd3);
        check("p3_state", 32'(state), 32'd1);
        check("p3_load_ready", 32'(load_ready), 32'd0);
        check("p3_loaded_insn", instruction, 32'h0);

        PC = 8'd0;
        pulse_start();
        check("run_state", 32'(state), 32'd2);
        check("run_count0", 32'(cycle_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            PC = 8'(i % 3);
            #1;
            check($sformatf("run_insn_%0d", i), instruction, prog3[i % 3]);
            tick();
        end
        check("run_count5", 32'(cycle_count), 32'd5);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("halt_state", 32'(state), 32'd3);
        check("halt_count", 32'(cycle_count), 32'd5);
        check("halt_insn", instruction, 32'h0);
        check("halt_pc_fault", 32'(pc_fault), 32'd0);
        tick();
        check("halt_count_frozen", 32'(cycle_count), 32'd5);

        // Restart from HALT, fetch out of range.
        pulse_start();
        check("rerun_state", 32'(state), 32'd2);
        check("rerun_count_clr", 32'(cycle_count), 32'd0);
        PC = 8'd7;
        #1;
        check("oor_insn", instruction, 32'h0);
        tick();
        check("oor_pc_fault", 32'(pc_fault), 32'd1);
        PC = 8'd0;
        #1;
        check("back_insn", instruction, 32'h2001_0005);
        tick();
        check("sticky_pc_fault", 32'(pc_fault), 32'd1);
        check("rerun_count2", 32'(cycle_count), 32'd2);

        // done and start together in RUN: done wins.
        done = 1'b1; start = 1'b1;
        tick();
        done = 1'b0; start = 1'b0;
        check("done_beats_start", 32'(state), 32'd3);

        // clear and start together in HALT: clear wins.
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        check("clr_state", 32'(state), 32'd0);
        check("clr_prog_len", 32'(prog_len), 32'd0);
        check("clr_pc_fault", 32'(pc_fault), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_count", 32'(cycle_count), 32'd0);

        // Twelve words without last: overflow.
        for (int i = 0; i < 11; i++) load_word(32'h1000_0000 + 32'(i), 1'b0);
        check("ov11_state", 32'(state), 32'd0);
        check("ov11_ready", 32'(load_ready), 32'd1);
        load_word(32'h1000_000B, 1'b0);
        check("ov_state", 32'(state), 32'd1);
        check("ov_overflow", 32'(overflow), 32'd1);
        check("ov_ready", 32'(load_ready), 32'd0);
        check("ov_prog_len", 32'(prog_len), 32'd12);
        load_word(32'hDEAD_BEEF, 1'b1);
        check("ov13_prog_len", 32'(prog_len), 32'd12);
        check("ov13_state", 32'(state), 32'd1);
        PC = 8'd11;
        pulse_start();
        check("ov_last_slot", instruction, 32'h1000_000B);
        PC = 8'd3;
        #1;
        check("ov_slot3", instruction, 32'h1000_0003);
        PC = 8'd12;
        #1;
        check("ov_pc12_insn", instruction, 32'h0);
        tick();
        check("ov_pc12_fault", 32'(pc_fault), 32'd1);
        PC = 8'd0;
        pulse_clear();

        // Exact fill with last on the twelfth word: no overflow.
        for (int i = 0; i < 12; i++) load_word(32'h3000_0000 + 32'(i), i == 11);
        check("fill_state", 32'(state), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        check("fill_prog_len", 32'(prog_len), 32'd12);
        pulse_clear();

        // Asynchronous reset between edges during a load.
        load_word(32'h2001_0005, 1'b0);
        load_word(32'h2002_0003, 1'b0);
        check("pre_rst_prog_len", 32'(prog_len), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("async_prog_len", 32'(prog_len), 32'd0);
        check("async_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_prog_len", 32'(prog_len), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_program_loader

// File: doc/program_loader.md
Name: program_loader

Overview:
- Instruction-side partner of the processor: accepts a program over a valid/ready load stream, stores it, then serves `instruction` for the processor's `PC` while the program runs.
- Watches the processor's `done` to end a run, counts run cycles and flags fetches beyond the loaded program.
- Sits beside the processor in the top-level bench; `PC`/`done` come from the processor, `instruction` goes to it.

Parameters:
- DEPTH, 12, instruction slots (addresses 0..DEPTH-1; matches processor MAX_PC 11).
- INSN_W, 32, instruction width.
- NOP_INSN, 32'h0000_0000, word returned for out-of-range PC or when not running.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data holds a program word.
- load_ready  output  1  block accepts a word this cycle.
- load_data  input  INSN_W  program word, bit 0 = MSB (matches processor `instruction[0:31]`).
- load_last  input  1  qualifies final word of the program.
- start  input  1  single-cycle pulse: begin run.
- clear  input  1  single-cycle pulse: discard program, return to IDLE.
- PC  input  8  processor program counter.
- done  input  1  processor halt indication.
- instruction  output  INSN_W  word for current PC.
- state  output  2  IDLE=0, LOADED=1, RUN=2, HALT=3.
- prog_len  output  8  number of words stored.
- overflow  output  1  sticky: program exceeded DEPTH.
- pc_fault  output  1  sticky: PC >= prog_len seen during RUN.
- cycle_count  output  16  RUN cycles of the current run, saturating at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prog_len=0, overflow=0, pc_fault=0, cycle_count=0. Memory contents are not reset. instruction=NOP_INSN.
- load_ready=1 only in IDLE with prog_len<DEPTH.
- A word is accepted on a rising edge with load_valid&&load_ready. It is written to mem[prog_len], then prog_len increments.
- IDLE -> LOADED when the accepted word has load_last=1.
- IDLE -> LOADED with overflow=1 when the accepted word fills slot DEPTH-1 with load_last=0. Later load_valid is ignored (load_ready=0).
- load_last on a word that exactly fills DEPTH: LOADED, overflow=0.
- start in IDLE or RUN is ignored.
- start in LOADED or HALT -> RUN. cycle_count and pc_fault clear on entry.
- RUN:
  - instruction = mem[PC] combinationally (zero latency; the processor samples it at the same edge that uses PC).
  - PC >= prog_len: instruction=NOP_INSN and pc_fault sets at the edge.
  - cycle_count increments every RUN cycle and saturates.
- RUN -> HALT on the edge where done=1. cycle_count does not count that cycle.
- HALT: cycle_count and pc_fault frozen. instruction=NOP_INSN.
- In any state other than RUN, instruction=NOP_INSN.
- clear (any state) -> IDLE with prog_len=0, overflow=0, pc_fault=0, cycle_count=0.
- Simultaneous events:
  - clear has priority over start, done and load.
  - done and start together in RUN: done wins (HALT).
- rst_n low mid-load or mid-run aborts immediately to reset values. The program must then be reloaded.
- prog_len=0 is reachable only in IDLE; LOADED always has prog_len>=1.

Decomposition:
- Shared package/header holds: state encodings (IDLE/LOADED/RUN/HALT), NOP_INSN and the DEPTH default. This mirrors the existing state-definition header style.
- One sub-module is natural: `insn_store`, a DEPTH x INSN_W register array with a synchronous write port and a combinational read port.
- The FSM, counters and flags stay in program_loader.

Test Plan:
- Load 3 words (0x2001_0005, 0x2002_0003, 0x0022_1820 with last) -> prog_len=3, state=LOADED; PC=1 in RUN -> instruction=0x2002_0003.
- Load 12 words, none with last -> after the 12th accept, state=LOADED, overflow=1, load_ready=0; a 13th valid is not stored and prog_len stays 12.
- Run with PC held 0..2 for 5 cycles, then done=1 -> state=HALT, cycle_count=5, instruction=NOP_INSN.
- RUN with prog_len=3 and PC=7 -> instruction=0, pc_fault=1; pc_fault remains 1 after PC returns to 0.
- clear and start in the same cycle while in HALT -> state=IDLE, prog_len=0, all flags 0.
- rst_n low for 1 ns mid-load (between edges) after 2 words -> outputs reset immediately; prog_len=0 and state=IDLE before the next edge.
